// File: rtl/bnn_seq_ctrl.sv
// Time-multiplexed 8-8-4 binary neural network sequencer: one XNOR-popcount-threshold
// unit evaluates one neuron per cycle, hidden layer first, then output layer.
module bnn_seq_ctrl #(
    parameter int unsigned NUM_L1 = 8,
    parameter int unsigned NUM_L2 = 4,
    parameter int unsigned THRESH = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [7:0] hidden_data,
    input  logic       wr_en,
    output logic       wr_ready,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_err,
    output logic       busy
);

    localparam int unsigned NumN = NUM_L1 + NUM_L2;

    typedef enum logic [1:0] {StIdle, StL1, StL2, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] x_q, x_d;
    logic [7:0] hidden_q, hidden_d;
    logic [3:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       wr_err_q, wr_err_d;
    logic [7:0] w_q [NumN];

    logic [7:0] operand, weight, match;
    logic [3:0] pc;
    logic       fire, in_hs, wr_hs, wr_ok;

    assign in_ready    = (state_q == StIdle);
    assign wr_ready    = (state_q == StIdle);
    assign busy        = (state_q == StL1) || (state_q == StL2);
    assign out_valid   = out_valid_q;
    assign out_data    = out_q;
    assign hidden_data = hidden_q;
    assign wr_err      = wr_err_q;

    assign in_hs = in_valid && in_ready;
    assign wr_hs = wr_en && wr_ready;
    assign wr_ok = wr_hs && (wr_addr < 4'(NumN));

    // Shared neuron unit; the output layer reads the completed hidden vector.
    always_comb begin
        operand = (state_q == StL2) ? hidden_q : x_q;
        weight  = (idx_q < 4'(NumN)) ? w_q[idx_q] : 8'h00;
        match   = ~(operand ^ weight);
        pc      = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pc = pc + {3'b000, match[i]};
        end
        fire = (pc >= 4'(THRESH));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        hidden_d    = hidden_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        wr_err_d    = wr_err_q | (wr_hs && !wr_ok);
        unique case (state_q)
            StIdle: begin
                if (in_hs) begin
                    x_d     = in_data;
                    idx_d   = 4'd0;
                    state_d = StL1;
                end
            end
            StL1: begin
                hidden_d[idx_q[2:0]] = fire;
                if (idx_q == 4'(NUM_L1 - 1)) begin
                    idx_d   = 4'(NUM_L1);
                    state_d = StL2;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StL2: begin
                out_d[2'(idx_q - 4'(NUM_L1))] = fire;
                if (idx_q == 4'(NumN - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            x_q         <= 8'h00;
            hidden_q    <= 8'h00;
            out_q       <= 4'h0;
            out_valid_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            hidden_q    <= hidden_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wr_err_q    <= wr_err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NumN); i++) begin
                w_q[i] <= 8'h00;
            end
        end else if (wr_ok) begin
            w_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: doc/bnn_seq_ctrl.md
Name: bnn_seq_ctrl

Overview:
Time-multiplexed sequencer for the 8-8-4 binary neural network. It shares one 8-bit XNOR-popcount-threshold unit across all 12 neurons: 8 hidden, then 4 output. It evaluates one neuron per cycle from an internal weight register file. It also arbitrates that register file between the host weight-write port and inference, and exposes valid/ready handshakes on input and result.

Parameters:
NUM_L1, 8, hidden-layer neuron count (indices 0..NUM_L1-1)
NUM_L2, 4, output-layer neuron count (indices NUM_L1..NUM_L1+NUM_L2-1)
THRESH, 6, activation threshold; neuron fires when popcount >= THRESH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept input vector
in_data  in  8  binary input vector
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  4  output-layer activations; bit k = neuron NUM_L1+k
hidden_data  out  8  hidden-layer activations of the current/last inference
wr_en  in  1  weight write request
wr_ready  out  1  weight write accepted this cycle
wr_addr  in  4  neuron index 0..11
wr_data  in  8  weight byte; bit i pairs with input bit i
wr_err  out  1  sticky: a write to addr >= 12 was attempted
busy  out  1  high in L1 or L2

Behaviour:
- Reset (async): state IDLE; idx=0; all 12 weights=8'h00; hidden_data=0; out_data=0; out_valid=0; wr_err=0.
- States: IDLE, L1, L2, DONE.
- Control outputs:
  - in_ready = (state==IDLE).
  - wr_ready = (state==IDLE).
  - busy = (state==L1 || L2).
- IDLE:
  - On in_valid&in_ready, latch in_data into x_reg, set idx=0, go to L1.
  - hidden_data is not cleared; it is overwritten progressively.
- L1, each cycle:
  - pc = popcount(~(x_reg ^ w[idx])), a 4-bit value 0..8.
  - At the clock edge, hidden[idx] <= (pc >= THRESH).
  - idx increments. When idx==NUM_L1-1, go to L2 with idx=NUM_L1.
- L2, each cycle:
  - Same unit with operand hidden_data (fully updated) instead of x_reg.
  - out_data[idx-NUM_L1] <= (pc >= THRESH).
  - When idx==NUM_L1+NUM_L2-1, go to DONE and set out_valid=1.
- Latency: out_valid rises exactly NUM_L1+NUM_L2 = 12 cycles after the input-handshake edge.
- DONE:
  - out_valid=1. out_data and hidden_data are held stable while out_ready=0.
  - On out_ready, out_valid clears at the edge and the state returns to IDLE.
  - The next input is accepted no earlier than the cycle after the result handshake. Peak throughput is 1 inference per 14 cycles.
- out_data is updated only in L2. It may change bit-by-bit during L2, but is only meaningful while out_valid=1.
- Weight writes:
  - A write occurs when wr_en&wr_ready and wr_addr<12; w[wr_addr] <= wr_data at that edge.
  - wr_en outside IDLE is not accepted (wr_ready=0) and has no effect. The requester must hold the request.
  - A write with wr_addr>=12 sets wr_err (sticky until reset) and changes no weight.
- Simultaneous write and input handshake in IDLE: both are accepted at the same edge. The inference uses the newly written weight.
- Pipeline freedom: the popcount unit is combinational within the cycle; no extra pipeline stage is permitted (latency is fixed at 12).
- Reset mid-inference or in DONE: immediate return to IDLE with reset values. All loaded weights are lost (revert to 0).

Test Plan:
- Reset, all weights 0, in_data=8'h00 -> hidden_data=8'hFF, out_data=4'h0, out_valid rises 12 cycles after the handshake.
- All weights 0, in_data=8'hFF -> hidden_data=8'h00, out_data=4'hF.
- Write w[8]=8'hFF in IDLE, then in_data=8'hFF -> hidden=8'h00, out_data=4'hE. Write w[0]=8'h0F with in_data=8'h0F -> hidden[0]=1.
- Hold out_ready=0 for 20 cycles in DONE -> out_valid, out_data, hidden_data stable; in_ready=0; wr_en during L1 is not accepted (wr_ready=0) and weights are unchanged. After out_ready=1, IDLE is reached the next cycle.
- wr_addr=4'd13, wr_data=8'hAA -> wr_err=1, weights unchanged, inference result identical to the baseline.
- Assert reset at cycle 5 of L1 -> in_ready=1, out_valid=0, busy=0. Weights read back via inference equal all-zero behaviour (in_data=8'h00 -> out_data=4'h0).
